// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Parametrised N-bit adder/subtractor whose carry chain is split into
//   STAGES registered segments of W = N/STAGES bits. Each slot carries its
//   not-yet-added upper operand segments and its finished lower sum
//   segments through skew registers. The whole pipeline advances together
//   when the output register is empty or being consumed. Otherwise it stalls.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   A, B, Cin, Sub      operands; Sub=1 computes A-B and ignores Cin
//   in_valid/in_ready   operand handshake (in_ready = advance)
//   Sum, Cout, Ovf      registered result, carry out, signed overflow
//   out_valid/out_ready result handshake
module pipelined_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         Sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int W = N / STAGES;

    logic                     adv;
    logic [STAGES-1:0]        vld_d, vld_q;
    logic [STAGES-1:0]        c_d, c_q;
    logic [STAGES-1:0][N-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
    logic                     ovf_d, ovf_q;

    // The last stage's operand skew registers are never read. Fold them into
    // a sink so they are visibly intentional and get trimmed by synthesis.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign adv = ~vld_q[STAGES-1] | out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [N-1:0] a_i, b_i, s_i, sum_k;
        logic         c_i, v_i;
        logic [W:0]   seg;

        if (k == 0) begin : g_head
            // B is inverted once at entry, so later stages never see Sub.
            assign a_i = A;
            assign b_i = Sub ? ~B : B;
            assign s_i = '0;
            assign c_i = Sub | Cin;
            assign v_i = in_valid;
        end else begin : g_body
            assign a_i = a_q[k-1];
            assign b_i = b_q[k-1];
            assign s_i = s_q[k-1];
            assign c_i = c_q[k-1];
            assign v_i = vld_q[k-1];
        end

        always_comb begin
            seg             = {1'b0, a_i[k*W +: W]} + {1'b0, b_i[k*W +: W]} + {{W{1'b0}}, c_i};
            sum_k           = s_i;
            sum_k[k*W +: W] = seg[W-1:0];
        end

        assign a_d[k]   = a_i;
        assign b_d[k]   = b_i;
        assign s_d[k]   = sum_k;
        assign c_d[k]   = seg[W];
        assign vld_d[k] = v_i;

        if (k == STAGES - 1) begin : g_tail
            // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
            assign ovf_d = seg[W] ^ (a_i[N-1] ^ b_i[N-1] ^ sum_k[N-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_d;
            // Bubbles leave data registers untouched, so Sum keeps the last
            // valid result and idle slots do not toggle.
            for (int k = 0; k < STAGES; k++) begin
                if (vld_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (vld_d[STAGES-1]) ovf_q <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign Sum       = s_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign Ovf       = ovf_q;
    assign out_valid = vld_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder: three instances (32/4, 8/2, 16/1) tested one
// at a time through a shared scoreboard queue.
module tb_pipelined_adder;
    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          t;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    localparam int NW [3] = '{32, 8, 16};
    localparam int ST [3] = '{4, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic [31:0] a    [3];
    logic [31:0] b    [3];
    logic        cin  [3];
    logic        sub  [3];
    logic        iv   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ovl  [3];
    logic        co   [3];
    logic        ovf  [3];
    logic [31:0] sum  [3];
    logic [7:0]  s1;
    logic [15:0] s2;

    assign sum[1] = {24'b0, s1};
    assign sum[2] = {16'b0, s2};

    pipelined_adder #(.N(32), .STAGES(4)) u0 (
        .clk(clk), .rst(rst[0]), .A(a[0]), .B(b[0]), .Cin(cin[0]), .Sub(sub[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .Sum(sum[0]), .Cout(co[0]), .Ovf(ovf[0]),
        .out_valid(ovl[0]), .out_ready(ordy[0]));

    pipelined_adder #(.N(8), .STAGES(2)) u1 (
        .clk(clk), .rst(rst[1]), .A(a[1][7:0]), .B(b[1][7:0]), .Cin(cin[1]), .Sub(sub[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .Sum(s1), .Cout(co[1]), .Ovf(ovf[1]),
        .out_valid(ovl[1]), .out_ready(ordy[1]));

    pipelined_adder #(.N(16), .STAGES(1)) u2 (
        .clk(clk), .rst(rst[2]), .A(a[2][15:0]), .B(b[2][15:0]), .Cin(cin[2]), .Sub(sub[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .Sum(s2), .Cout(co[2]), .Ovf(ovf[2]),
        .out_valid(ovl[2]), .out_ready(ordy[2]));

    int   act = 0;
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;
    bit   lat_chk = 1'b1;
    bit   done = 1'b0;
    exp_t cexp;
    exp_t q[$];
    vec_t tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h (unit %0d, cycle %0d)", nm, got, want, act, cyc);
        end
    endtask

    // Independent reference: wide add, sign-rule overflow.
    function automatic exp_t model(int i, logic [31:0] x, logic [31:0] y, logic ci, logic sb);
        logic [63:0] m, xx, yy, f;
        exp_t e;
        int n;
        n  = NW[i];
        m  = (64'd1 << n) - 64'd1;
        xx = {32'b0, x} & m;
        yy = (sb ? ~{32'b0, y} : {32'b0, y}) & m;
        f  = xx + yy + (sb ? 64'd1 : {63'b0, ci});
        e.s  = f[31:0] & m[31:0];
        e.co = f[n];
        e.ov = (xx[n-1] == yy[n-1]) && (f[n-1] != xx[n-1]);
        e.t  = 0;
        return e;
    endfunction

    // Scoreboard: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst[act]) begin
            q.delete();
        end else begin
            if (ovl[act] && ordy[act]) begin
                if (q.size() == 0) begin
                    nvec++;
                    nbad++;
                    $display("FAIL extra_result: got sum=%0h, expected no output (unit %0d)", sum[act], act);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum[act], e.s);
                    chk("cout", co[act], e.co);
                    chk("ovf", ovf[act], e.ov);
                    if (lat_chk) chk("latency", cyc - e.t, ST[act]);
                end
            end
            if (iv[act] && ir[act]) begin
                e   = cexp;
                e.t = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, input exp_t e);
        bit ok;
        int k;
        a[act] = x; b[act] = y; cin[act] = ci; sub[act] = sb;
        cexp = e;
        iv[act] = 1'b1;
        ok = 1'b0;
        k = 0;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = ir[act];
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) begin
            nvec++;
            nbad++;
            $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", k);
        end
        iv[act] = 1'b0;
    endtask

    task automatic sendm(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
        send(x, y, ci, sb, model(act, x, y, ci, sb));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [31:0] m, x, y;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; a[i] = '0; b[i] = '0; cin[i] = 1'b0;
            sub[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1;
        end
        tbl[0] = '{32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[1] = '{32'h0,        32'h0,        1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        tbl[2] = '{32'h1,        32'h3,        1'b1, 1'b0, 32'h00000005, 1'b0, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[4] = '{32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[5] = '{32'h5,        32'h7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[6] = '{32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[7] = '{32'h9,        32'h4,        1'b1, 1'b1, 32'h00000005, 1'b1, 1'b0};
        tbl[8] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
        tbl[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

        // Reset state of the 32/4 unit
        act = 0;
        idle(3);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", ovl[0], 0);
        chk("rst_sum", sum[0], 0);
        chk("rst_cout", co[0], 0);
        chk("rst_ovf", ovf[0], 0);
        chk("rst_in_ready", ir[0], 1);
        @(posedge clk);
        #1;

        // Directed table, one per cycle, latency checked
        lat_chk = 1'b1;
        for (int j = 0; j < 10; j++) begin
            e = '{tbl[j].s, tbl[j].co, tbl[j].ov, 0};
            send(tbl[j].a, tbl[j].b, tbl[j].ci, tbl[j].sb, e);
        end
        drain();

        // Back-pressure: hold out_ready low 3 cycles once out_valid rises
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    e = '{32'(2 * i), 1'b0, 1'b0, 0};
                    send(32'(i), 32'(i), 1'b0, 1'b0, e);
                end
            end
            begin
                int k;
                k = 0;
                while (!ovl[0] && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                ordy[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_in_ready", ir[0], 0);
                    chk("hold_out_valid", ovl[0], 1);
                    chk("hold_sum", sum[0], 2);
                    @(posedge clk);
                    #1;
                end
                ordy[0] = 1'b1;
            end
        join
        drain();

        // Reset with three results in flight
        lat_chk = 1'b1;
        sendm(32'd10, 32'd1, 1'b0, 1'b0);
        sendm(32'd20, 32'd1, 1'b0, 1'b0);
        sendm(32'd30, 32'd1, 1'b0, 1'b0);
        rst[0] = 1'b1;
        idle(1);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", ovl[0], 0);
        chk("midrst_sum", sum[0], 0);
        @(posedge clk);
        #1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_valid", ovl[0], 0);
            @(posedge clk);
            #1;
        end
        e = '{32'd4, 1'b0, 1'b0, 0};
        send(32'd2, 32'd2, 1'b0, 1'b0, e);
        drain();

        // Parameter sweep: 8/2 and 16/1 against the reference model
        for (int i = 1; i < 3; i++) begin
            act = i;
            rst[i] = 1'b1;
            idle(2);
            rst[i] = 1'b0;
            lat_chk = 1'b1;
            m = 32'((64'd1 << NW[i]) - 64'd1);
            sendm(m, 32'd1, 1'b0, 1'b0);
            sendm(m >> 1, 32'd1, 1'b0, 1'b0);
            sendm((m >> 1) + 32'd1, 32'd1, 1'b0, 1'b1);
            sendm(32'd0, 32'd0, 1'b1, 1'b0);
            sendm(m, m, 1'b1, 1'b0);
            for (int j = 0; j < 200; j++) begin
                x = $urandom() & m;
                y = $urandom() & m;
                sendm(x, y, 1'(j % 2), 1'($urandom_range(0, 1)));
            end
            drain();
            lat_chk = 1'b0;
            done = 1'b0;
            fork
                begin
                    for (int j = 0; j < 200; j++) begin
                        x = $urandom() & m;
                        y = $urandom() & m;
                        sendm(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        ordy[i] = 1'($urandom_range(0, 1));
                        @(posedge clk);
                        #1;
                    end
                    ordy[i] = 1'b1;
                end
            join
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined N-bit adder/subtractor; successor to the single-cycle 32-bit combinational adder.
- Splits the carry chain into STAGES registered segments to meet cycle time on wide datapaths.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake with back-pressure.
- Sits between operand-issue logic and the writeback/accumulate path in the ALU datapath.

Parameters:
- N, 32, operand and sum width in bits.
- STAGES, 4, number of pipeline stages; N must be divisible by STAGES; segment width W = N/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A.
- B  input  N  operand B.
- Cin  input  1  carry-in; used only when Sub=0.
- Sub  input  1  mode: 0 = A+B+Cin, 1 = A-B (A + ~B + 1).
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  pipeline can accept operands this cycle.
- Sum  output  N  result, N LSBs.
- Cout  output  1  carry out of bit N-1 (Sub=1: 1 = no borrow).
- Ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.
- out_valid  output  1  Sum/Cout/Ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits cleared; Sum=0, Cout=0, Ovf=0, out_valid=0.
  - Reset mid-operation discards every in-flight result; none is emitted after reset.
  - in_ready=1 in the first cycle after reset when out_ready=1.
- Advance condition: adv = ~out_valid | out_ready. The whole pipeline moves one stage when adv=1 and freezes otherwise (global stall).
- Handshake:
  - in_ready = adv, combinational.
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Bubbles (in_valid=0 while adv=1) propagate as invalid slots.
- Stage k (0..STAGES-1) adds segment bits [k*W +: W] of A and B', where B' = Sub ? ~B : B.
  - Carry-in of stage 0 = Sub ? 1 : Cin.
  - Carry-in of stage k>0 = the registered carry out of stage k-1.
  - Unprocessed upper operand segments and completed lower sum segments travel with their slot through skew registers.
- Latency: exactly STAGES cycles from the input transfer to out_valid=1 for that result, with no stalls.
  - Each stall cycle adds one cycle.
  - Throughput: one result per cycle while out_ready=1.
- Outputs are registered (final stage registers).
  - While out_valid=1 and out_ready=0, Sum/Cout/Ovf/out_valid hold stable.
  - Results emerge strictly in input order; none is dropped or duplicated.
- Arithmetic is modulo 2^N. Cout and Ovf are computed on the full N-bit result in the last stage.
  - The carry into bit N-1 is taken inside the last segment.
- STAGES=1 degenerates to a single registered adder with latency 1.
- A simultaneous input transfer and output transfer in the same cycle is legal and sustains full throughput.

Test Plan:
- Directed additions, N=32, STAGES=4, out_ready=1, one per cycle:
  - A=FFFFFFFF, B=0, Cin=0 -> Sum=FFFFFFFF, Cout=0, Ovf=0.
  - A=0, B=0, Cin=1 -> Sum=00000001, Cout=0.
  - A=1, B=3, Cin=1 -> Sum=00000005.
  - Results appear on cycles 4, 5 and 6 after the first transfer, in order.
- Carry across all segments: A=FFFFFFFF, B=1, Cin=0 -> Sum=0, Cout=1, Ovf=0. Signed overflow: A=7FFFFFFF, B=1 -> Sum=80000000, Cout=0, Ovf=1.
- Subtract:
  - Sub=1, A=5, B=7 -> Sum=FFFFFFFE, Cout=0, Ovf=0.
  - Sub=1, A=80000000, B=1 -> Sum=7FFFFFFF, Cout=1, Ovf=1.
  - Sub=1, Cin=1 is ignored: A=9, B=4 -> Sum=5.
- Back-pressure: stream 8 operand pairs (A=i, B=i for i=1..8) while holding out_ready=0 for 3 cycles once out_valid first rises.
  - in_ready=0 and the outputs are stable during the hold.
  - All 8 results (2,4,...,16) are delivered in order exactly once.
- Reset mid-flight: issue 3 transfers, assert rst for 1 cycle after the 2nd cycle.
  - out_valid=0 and Sum=0 after reset.
  - No stale results appear; a new transfer A=2, B=2 yields Sum=4 after 4 cycles.
- Parameter sweep: N=8, STAGES=2 and N=16, STAGES=1.
  - Exhaustive/random compare against an A+B'+cin reference model.
  - Latency equals STAGES.
